// File: rtl/rs_age_multicdb.sv
// ---------------------------------------------------------------------------
// buffer_pkgs: shared physical-tag width and the reservation-station entry.
// ---------------------------------------------------------------------------
package buffer_pkgs;
    localparam int PREG_W = 6;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic              valid;
        logic [7:0]        uop_id;
        logic              rs1_rdy;
        logic [PREG_W-1:0] rs1_tag;
        logic [XLEN-1:0]   rs1_val;
        logic              rs2_rdy;
        logic [PREG_W-1:0] rs2_tag;
        logic [XLEN-1:0]   rs2_val;
    } rs_entry_t;
endpackage

// ---------------------------------------------------------------------------
// rs_age_multicdb: reservation station between dispatch and one FU.
//
// Holds up to RS_DEPTH uops, captures operands from NUM_CDB result buses,
// picks the oldest ready entry using an age matrix and hands it to the FU
// through a one-entry registered issue stage.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   flush_i            empties station and issue stage (highest priority)
//   disp_valid_i/ready_o/entry_i   dispatch handshake and uop
//   issue_valid_o/ready_i/entry_o  issue handshake and registered uop
//   cdb_valid_i/tag_i/data_i       NUM_CDB flattened result buses
//   occupancy_o        number of valid entries (issue register excluded)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. disp_ready_o never depends on disp_valid_i. issue_entry_o is held
// stable while issue_valid_o && !issue_ready_i, and is '0 when not valid.
// ---------------------------------------------------------------------------
module rs_age_multicdb #(
    parameter type RS_ENTRY_T = buffer_pkgs::rs_entry_t,
    parameter int  RS_DEPTH   = 8,
    parameter int  NUM_CDB    = 2,
    parameter int  PREG_W     = buffer_pkgs::PREG_W,
    parameter int  DATA_W     = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            disp_valid_i,
    output logic                            disp_ready_o,
    input  RS_ENTRY_T                       disp_entry_i,
    output logic                            issue_valid_o,
    input  logic                            issue_ready_i,
    output RS_ENTRY_T                       issue_entry_o,
    input  logic [NUM_CDB-1:0]              cdb_valid_i,
    input  logic [NUM_CDB*PREG_W-1:0]       cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0]       cdb_data_i,
    output logic [$clog2(RS_DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(RS_DEPTH+1);

    RS_ENTRY_T             entries_q [RS_DEPTH];
    RS_ENTRY_T             entries_d [RS_DEPTH];
    // older_q[i][j] = 1: entry i is older than entry j (only meaningful
    // when both are valid; freed rows/columns keep stale bits).
    logic [RS_DEPTH-1:0]   older_q   [RS_DEPTH];
    logic [RS_DEPTH-1:0]   older_d   [RS_DEPTH];
    RS_ENTRY_T             issue_q, issue_d;
    logic                  issue_valid_q, issue_valid_d;

    logic [OCC_W-1:0]      occ;
    logic [RS_DEPTH-1:0]   valid_vec;
    logic [RS_DEPTH-1:0]   cand;
    logic [RS_DEPTH-1:0]   sel_oh;
    logic [RS_DEPTH-1:0]   ins_oh;
    logic                  any_cand;
    logic                  ins;
    logic                  issue_load;
    logic                  found;
    RS_ENTRY_T             sel_entry;

    // Operand capture from all buses. Buses are scanned from the highest
    // index down so the lowest-index bus carrying a matching tag wins.
    // Matching always uses the incoming entry's fields, so both operands can
    // wake from different buses in the same cycle.
    function automatic RS_ENTRY_T wake(input RS_ENTRY_T e,
                                       input logic [NUM_CDB-1:0] cv,
                                       input logic [NUM_CDB*PREG_W-1:0] ct,
                                       input logic [NUM_CDB*DATA_W-1:0] cd);
        RS_ENTRY_T         r;
        logic [PREG_W-1:0] t;
        r = e;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            t = ct[b*PREG_W +: PREG_W];
            if (cv[b] && (t != '0)) begin
                if (!e.rs1_rdy && (e.rs1_tag == t)) begin
                    r.rs1_rdy = 1'b1;
                    r.rs1_val = cd[b*DATA_W +: DATA_W];
                    r.rs1_tag = '0;
                end
                if (!e.rs2_rdy && (e.rs2_tag == t)) begin
                    r.rs2_rdy = 1'b1;
                    r.rs2_val = cd[b*DATA_W +: DATA_W];
                    r.rs2_tag = '0;
                end
            end
        end
        return r;
    endfunction

    // Occupancy and candidate vector from registered state only, so an
    // entry woken this cycle becomes selectable next cycle.
    always_comb begin
        occ       = '0;
        valid_vec = '0;
        cand      = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            valid_vec[i] = entries_q[i].valid;
            cand[i]      = entries_q[i].valid && entries_q[i].rs1_rdy &&
                           entries_q[i].rs2_rdy;
            occ          = occ + OCC_W'(entries_q[i].valid);
        end
    end

    // Oldest-ready select: candidate i wins if it is older than every other
    // candidate. The age order is total over valid entries, so at most one
    // bit of sel_oh is set.
    always_comb begin
        sel_oh = cand;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if ((j != i) && cand[j] && !older_q[i][j]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
        any_cand  = |cand;
        sel_entry = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_entry = entries_q[i];
            end
        end
    end

    // Dispatch goes to the lowest slot that is free in registered state; a
    // slot vacated by issue this cycle is still seen as occupied.
    assign disp_ready_o = (occ < OCC_W'(RS_DEPTH)) && !flush_i;
    assign ins          = disp_valid_i && disp_ready_o;
    assign issue_load   = (!issue_valid_q || issue_ready_i) && any_cand && !flush_i;

    always_comb begin
        ins_oh = '0;
        found  = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!entries_q[i].valid && !found) begin
                ins_oh[i] = ins;
                found     = 1'b1;
            end
        end
    end

    // Entry array and age matrix next state.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            older_d[i]   = older_q[i];
            if (issue_load && sel_oh[i]) begin
                entries_d[i].valid = 1'b0;
            end else if (entries_q[i].valid) begin
                entries_d[i] = wake(entries_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
            end
            if (ins_oh[i]) begin
                entries_d[i]       = wake(disp_entry_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
                entries_d[i].valid = 1'b1;
                // Newcomer is younger than everything currently held.
                older_d[i]         = '0;
            end
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                if (ins_oh[k] && valid_vec[i]) begin
                    older_d[i][k] = 1'b1;
                end
            end
        end
    end

    // Issue register next state.
    always_comb begin
        issue_d       = issue_q;
        issue_valid_d = issue_valid_q;
        if (issue_load) begin
            issue_d       = sel_entry;
            issue_valid_d = 1'b1;
        end else if (issue_ready_i) begin
            issue_d       = '0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= '0;
                older_q[i]   <= '0;
            end
            issue_q       <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
                older_q[i]   <= older_d[i];
            end
            issue_q       <= issue_d;
            issue_valid_q <= issue_valid_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_entry_o = issue_q;
    assign occupancy_o   = occ;

endmodule

// File: tb/tb_rs_age_multicdb.sv
// Directed bench for rs_age_multicdb (RS_DEPTH=8, NUM_CDB=2, PREG_W=6).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_rs_age_multicdb;
    import buffer_pkgs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    rs_entry_t   disp_entry;
    logic        issue_valid;
    logic        issue_ready;
    rs_entry_t   issue_entry;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [63:0] cdb_data;
    logic [3:0]  occupancy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rs_age_multicdb #(
        .RS_ENTRY_T (rs_entry_t),
        .RS_DEPTH   (8),
        .NUM_CDB    (2),
        .PREG_W     (6),
        .DATA_W     (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .disp_valid_i  (disp_valid),
        .disp_ready_o  (disp_ready),
        .disp_entry_i  (disp_entry),
        .issue_valid_o (issue_valid),
        .issue_ready_i (issue_ready),
        .issue_entry_o (issue_entry),
        .cdb_valid_i   (cdb_valid),
        .cdb_tag_i     (cdb_tag),
        .cdb_data_i    (cdb_data),
        .occupancy_o   (occupancy)
    );

    function automatic rs_entry_t mk(input logic [7:0] id,
                                     input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                                     input logic r2, input logic [5:0] t2, input logic [31:0] v2);
        rs_entry_t e;
        e.valid   = 1'b1;
        e.uop_id  = id;
        e.rs1_rdy = r1;
        e.rs1_tag = t1;
        e.rs1_val = v1;
        e.rs2_rdy = r2;
        e.rs2_tag = t2;
        e.rs2_val = v2;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input rs_entry_t e);
        disp_valid = 1'b1;
        disp_entry = e;
        tick();
        disp_valid = 1'b0;
        disp_entry = '0;
    endtask

    task automatic cdb_set(input int b, input logic [5:0] t, input logic [31:0] d);
        cdb_valid[b]        = 1'b1;
        cdb_tag[b*6 +: 6]   = t;
        cdb_data[b*32 +: 32] = d;
    endtask

    task automatic cdb_clr();
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_data  = '0;
    endtask

    task automatic chk_issue(input string tag, input rs_entry_t exp);
        chk({tag, "_v"}, 128'(issue_valid), 128'(1));
        chk({tag, "_e"}, 128'(issue_entry), 128'(exp));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_v"}, 128'(issue_valid), 128'(0));
        chk({tag, "_e"}, 128'(issue_entry), 128'(0));
    endtask

    rs_entry_t held;

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        disp_valid  = 1'b0;
        disp_entry  = '0;
        issue_ready = 1'b1;
        cdb_clr();

        // Reset for two cycles.
        tick();
        tick();
        chk_idle("rst");
        chk("rst_occ", 128'(occupancy), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 128'(disp_ready), 128'(1));

        // Fully ready uop A: issue_valid two edges after dispatch.
        disp(mk(8'h0A, 1, 0, 32'h1111_0000, 1, 0, 32'h2222_0000));
        chk("a_occ1", 128'(occupancy), 128'(1));
        chk("a_v1", 128'(issue_valid), 128'(0));
        tick();
        chk_issue("a_iss", mk(8'h0A, 1, 0, 32'h1111_0000, 1, 0, 32'h2222_0000));
        chk("a_occ0", 128'(occupancy), 128'(0));
        tick();
        chk_idle("a_clr");

        // B waits on tag 5 (slot 0), C ready (slot 1); C issues first.
        disp(mk(8'h0B, 0, 5, 0, 1, 0, 32'h0B0B));
        disp(mk(8'h0C, 1, 0, 32'hC1, 1, 0, 32'hC2));
        cdb_set(0, 6'd5, 32'hDEAD);
        tick();
        cdb_clr();
        chk_issue("c_iss", mk(8'h0C, 1, 0, 32'hC1, 1, 0, 32'hC2));
        chk("c_occ", 128'(occupancy), 128'(1));
        tick();
        chk_issue("b_iss", mk(8'h0B, 1, 0, 32'hDEAD, 1, 0, 32'h0B0B));
        tick();
        chk_idle("b_clr");

        // Age beats slot index: B2 in slot 1, D later into slot 0.
        disp(mk(8'h1A, 1, 0, 32'h1, 1, 0, 32'h2));
        disp(mk(8'h2B, 0, 6, 0, 1, 0, 32'h7));
        chk_issue("x_iss", mk(8'h1A, 1, 0, 32'h1, 1, 0, 32'h2));
        cdb_set(0, 6'd6, 32'hBEEF);
        disp(mk(8'h0D, 1, 0, 32'hD1, 1, 0, 32'hD2));
        cdb_clr();
        chk("bd_occ", 128'(occupancy), 128'(2));
        chk("bd_v", 128'(issue_valid), 128'(0));
        tick();
        chk_issue("b2_iss", mk(8'h2B, 1, 0, 32'hBEEF, 1, 0, 32'h7));
        tick();
        chk_issue("d_iss", mk(8'h0D, 1, 0, 32'hD1, 1, 0, 32'hD2));
        tick();
        chk_idle("d_clr");

        // Two buses wake both operands in one cycle.
        disp(mk(8'h0E, 0, 3, 0, 0, 4, 0));
        cdb_set(0, 6'd3, 32'h11);
        cdb_set(1, 6'd4, 32'h22);
        tick();
        cdb_clr();
        chk("e_v", 128'(issue_valid), 128'(0));
        tick();
        chk_issue("e_iss", mk(8'h0E, 1, 0, 32'h11, 1, 0, 32'h22));
        tick();

        // Both buses carry tag 3: bus 0 data wins.
        disp(mk(8'h0F, 0, 3, 0, 1, 0, 32'h5));
        cdb_set(0, 6'd3, 32'h11);
        cdb_set(1, 6'd3, 32'h33);
        tick();
        cdb_clr();
        tick();
        chk_issue("f_iss", mk(8'h0F, 1, 0, 32'h11, 1, 0, 32'h5));
        tick();
        chk_idle("f_clr");

        // Dispatch with a matching CDB tag in the same cycle.
        cdb_set(0, 6'd9, 32'h99);
        disp(mk(8'h60, 0, 9, 0, 1, 0, 32'h66));
        cdb_clr();
        chk("g_occ", 128'(occupancy), 128'(1));
        chk("g_v", 128'(issue_valid), 128'(0));
        tick();
        chk_issue("g_iss", mk(8'h60, 1, 0, 32'h99, 1, 0, 32'h66));
        tick();

        // Fill the station with 8 waiting uops.
        for (int i = 0; i < 8; i++) begin
            disp(mk(8'h40 + 8'(i), 0, 6'd10 + 6'(i), 0, 1, 0, 32'(i)));
        end
        chk("full_occ", 128'(occupancy), 128'(8));
        chk("full_rdy", 128'(disp_ready), 128'(0));
        cdb_set(1, 6'd13, 32'hC3);
        tick();
        cdb_clr();
        issue_ready = 1'b0;
        tick();
        held = mk(8'h43, 1, 0, 32'hC3, 1, 0, 32'h3);
        chk_issue("h_iss", held);
        chk("h_occ", 128'(occupancy), 128'(7));
        chk("h_rdy", 128'(disp_ready), 128'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_hold", 128'(issue_entry), 128'(held));
            chk("h_hold_occ", 128'(occupancy), 128'(7));
        end

        // Clean flush, then 5 waiting entries plus a held issue uop.
        flush = 1'b1;
        #1;
        chk("fl0_rdy", 128'(disp_ready), 128'(0));
        tick();
        flush = 1'b0;
        chk("fl0_occ", 128'(occupancy), 128'(0));
        chk_idle("fl0");
        disp(mk(8'h70, 1, 0, 32'h70, 1, 0, 32'h71));
        for (int i = 0; i < 5; i++) begin
            disp(mk(8'h80 + 8'(i), 0, 6'd20 + 6'(i), 0, 1, 0, 32'(i)));
        end
        chk("fl_occ5", 128'(occupancy), 128'(5));
        chk_issue("fl_held", mk(8'h70, 1, 0, 32'h70, 1, 0, 32'h71));
        flush      = 1'b1;
        disp_valid = 1'b1;
        disp_entry = mk(8'h90, 1, 0, 32'h90, 1, 0, 32'h91);
        #1;
        chk("fl_rdy", 128'(disp_ready), 128'(0));
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_entry = '0;
        chk("fl_occ", 128'(occupancy), 128'(0));
        chk_idle("fl");
        issue_ready = 1'b1;
        tick();
        chk("fl_drop_occ", 128'(occupancy), 128'(0));
        chk_idle("fl_drop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
